// File: rtl/led_scan_conditioner.sv
// Anti-ghosting blanking, global PWM dimming and column-select validation for an 8x8 LED matrix.
// Optional build macro SCAN_FRAME_TICK_EN adds a frame_tick pulse on entry to the last column.
module led_scan_conditioner #(
  parameter int BLANK_CYCLES = 64,
  parameter int PWM_BITS     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          col_in,
  input  logic [7:0]          row_in,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [7:0]          col_out,
  output logic [7:0]          row_out,
  output logic                blanking
`ifdef SCAN_FRAME_TICK_EN
  ,
  output logic                frame_tick
`endif
);

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

  state_t              state_q, state_d;
  logic [7:0]          col_q, col_d, row_q, row_d;
  logic [7:0]          held_col_q, held_col_d, held_row_q, held_row_d;
  logic [15:0]         blank_cnt_q, blank_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [7:0]          col_out_q, col_out_d, row_out_q, row_out_d;
  logic                blanking_q, blanking_d;
  logic [7:0]          col_n;
  logic                col_valid, col_same, pwm_en, go_on;

  // A valid select has exactly one low bit: its inverse is a non-zero power of two.
  always_comb begin
    col_n     = ~col_q;
    col_valid = (col_n != 8'h00) && ((col_n & (col_n - 8'd1)) == 8'h00);
    col_same  = col_valid && (col_q == held_col_q);
    pwm_en    = (brightness == '1) || (pwm_cnt_q < brightness);
    go_on     = (state_q == ST_BLANK) && col_same && (blank_cnt_q == BLANK_LAST);
  end

  always_comb begin
    col_d       = col_in;
    row_d       = row_in;
    pwm_cnt_d   = pwm_cnt_q + 1'b1;
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    held_col_d  = held_col_q;
    held_row_d  = held_row_q;
    col_out_d   = 8'hFF;
    row_out_d   = 8'h00;
    blanking_d  = 1'b1;
    case (state_q)
      ST_BLANK: begin
        if (!col_same) begin
          held_col_d  = col_q;
          blank_cnt_d = 16'd0;
        end else begin
          blank_cnt_d = blank_cnt_q + 16'd1;
          if (go_on) begin
            state_d    = ST_ON;
            held_row_d = row_q;
          end
        end
      end
      ST_ON: begin
        blanking_d = 1'b0;
        if (pwm_en) begin
          col_out_d = held_col_q;
          row_out_d = held_row_q;
        end
        // Row-only changes pass straight through; any column change re-blanks.
        if (!col_same) begin
          state_d     = ST_BLANK;
          held_col_d  = col_q;
          blank_cnt_d = 16'd0;
        end else begin
          held_row_d = row_q;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_BLANK;
      col_q       <= 8'hFF;
      row_q       <= 8'h00;
      held_col_q  <= 8'hFF;
      held_row_q  <= 8'h00;
      blank_cnt_q <= 16'd0;
      pwm_cnt_q   <= '0;
      col_out_q   <= 8'hFF;
      row_out_q   <= 8'h00;
      blanking_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      held_col_q  <= held_col_d;
      held_row_q  <= held_row_d;
      blank_cnt_q <= blank_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      col_out_q   <= col_out_d;
      row_out_q   <= row_out_d;
      blanking_q  <= blanking_d;
    end
  end

  assign col_out  = col_out_q;
  assign row_out  = row_out_q;
  assign blanking = blanking_q;

`ifdef SCAN_FRAME_TICK_EN
  logic frame_tick_q, frame_tick_d;

  always_comb frame_tick_d = go_on && (held_col_q == 8'hFE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_tick_q <= 1'b0;
    else        frame_tick_q <= frame_tick_d;
  end

  assign frame_tick = frame_tick_q;
`endif

endmodule
